// File: rtl/tl_line_master_if.sv
// Request/response and TileLink-UH A/D channel bundle for tl_line_master.
// The master modport is the line master's view; slave is the cache/memory side.
interface tl_line_master_if #(
  parameter int LG_BEATS = 2
);
  localparam int LINE_W = 128 << LG_BEATS;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [31:0]       req_addr;
  logic [LINE_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [LINE_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [2:0]        tlmst_a_opcode;
  logic [2:0]        tlmst_a_param;
  logic [7:0]        tlmst_a_size;
  logic [2:0]        tlmst_a_source;
  logic [31:0]       tlmst_a_address;
  logic [15:0]       tlmst_a_mask;
  logic [127:0]      tlmst_a_data;
  logic              tlmst_a_corrupt;
  logic              tlmst_a_valid;
  logic              tlmst_a_ready;

  logic [2:0]        tlmst_d_opcode;
  logic              tlmst_d_denied;
  logic [127:0]      tlmst_d_data;
  logic              tlmst_d_corrupt;
  logic              tlmst_d_valid;
  logic              tlmst_d_ready;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  tlmst_a_ready,
    input  tlmst_d_opcode, tlmst_d_denied, tlmst_d_data, tlmst_d_corrupt, tlmst_d_valid,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output tlmst_a_opcode, tlmst_a_param, tlmst_a_size, tlmst_a_source, tlmst_a_address,
    output tlmst_a_mask, tlmst_a_data, tlmst_a_corrupt, tlmst_a_valid,
    output tlmst_d_ready
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output tlmst_a_ready,
    output tlmst_d_opcode, tlmst_d_denied, tlmst_d_data, tlmst_d_corrupt, tlmst_d_valid,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  tlmst_a_opcode, tlmst_a_param, tlmst_a_size, tlmst_a_source, tlmst_a_address,
    input  tlmst_a_mask, tlmst_a_data, tlmst_a_corrupt, tlmst_a_valid,
    input  tlmst_d_ready
  );
endinterface

// File: rtl/tl_line_master.sv
// Single-outstanding TileLink-UH line master: one line request becomes a PutFullData burst or a Get.
// Optional D-channel watchdog enabled by defining TL_MASTER_TIMEOUT_EN.
module tl_line_master #(
  parameter int         LG_BEATS = 2,
  parameter logic [2:0] SRC_ID   = 3'd0,
  parameter int         TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  tl_line_master_if.master bus
);
  localparam int                BEATS      = 1 << LG_BEATS;
  localparam int                LINE_W     = 128 << LG_BEATS;
  localparam int                OFF_W      = LG_BEATS + 4;
  localparam logic [31:0]       ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [LG_BEATS-1:0] LAST     = LG_BEATS'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_D, RD_A, RD_D, RSP} state_t;

  state_t              r_state;
  logic [LG_BEATS-1:0] r_cnt;
  logic [LINE_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_reqReady;
  logic                r_rspValid;
  logic                r_aValid;
  logic [2:0]          r_aOpcode;
  logic [7:0]          r_aSize;
  logic [2:0]          r_aSource;
  logic [31:0]         r_aAddr;
  logic [15:0]         r_aMask;
  logic [127:0]        r_aData;
  logic                r_dReady;

  logic [LG_BEATS-1:0] w_cntNext;
  logic                w_aFire;
  logic                w_dFire;
  logic                w_dBad;

  assign w_cntNext = r_cnt + 1'b1;
  assign w_aFire   = r_aValid & bus.tlmst_a_ready;
  assign w_dFire   = r_dReady & bus.tlmst_d_valid;
  assign w_dBad    = bus.tlmst_d_denied | bus.tlmst_d_corrupt;

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int                TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]     r_toCnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_aValid   <= 1'b0;
      r_aOpcode  <= 3'd0;
      r_aSize    <= 8'd0;
      r_aSource  <= 3'd0;
      r_aAddr    <= 32'd0;
      r_aMask    <= 16'd0;
      r_aData    <= 128'd0;
      r_dReady   <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
      r_toCnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_reqReady) begin
            r_reqReady <= 1'b0;
            r_aValid   <= 1'b1;
            r_aAddr    <= bus.req_addr & ALIGN_MASK;
            r_aSize    <= 8'(OFF_W);
            r_aSource  <= SRC_ID;
            r_aMask    <= 16'hFFFF;
            r_wdata    <= bus.req_wdata;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            if (bus.req_wr) begin
              r_state   <= WR_A;
              r_aOpcode <= 3'd0;
              r_aData   <= bus.req_wdata[127:0];
            end else begin
              r_state   <= RD_A;
              r_aOpcode <= 3'd4;
              r_aData   <= 128'd0;
            end
          end
        end
        WR_A: begin
          if (w_aFire) begin
            if (r_cnt == LAST) begin
              r_cnt    <= '0;
              r_aValid <= 1'b0;
              r_aData  <= 128'd0;
              r_dReady <= 1'b1;
              r_state  <= WR_D;
            end else begin
              r_cnt   <= w_cntNext;
              r_aData <= r_wdata[128*w_cntNext +: 128];
            end
          end
        end
        WR_D: begin
          if (w_dFire) begin
            r_err      <= r_err | w_dBad | (bus.tlmst_d_opcode != 3'd0);
            r_dReady   <= 1'b0;
            r_rspValid <= 1'b1;
            r_state    <= RSP;
          end
        end
        RD_A: begin
          if (w_aFire) begin
            r_aValid <= 1'b0;
            r_dReady <= 1'b1;
            r_state  <= RD_D;
          end
        end
        RD_D: begin
          if (w_dFire) begin
            r_rdata[128*r_cnt +: 128] <= bus.tlmst_d_data;
            r_err <= r_err | w_dBad | (bus.tlmst_d_opcode != 3'd1);
            if (r_cnt == LAST) begin
              r_cnt      <= '0;
              r_dReady   <= 1'b0;
              r_rspValid <= 1'b1;
              r_state    <= RSP;
            end else begin
              r_cnt <= w_cntNext;
            end
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            r_rspValid <= 1'b0;
            r_reqReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_reqReady <= 1'b1;
        end
      endcase

`ifdef TL_MASTER_TIMEOUT_EN
      // Counts consecutive D-wait cycles without an accepted beat; expiry abandons the burst.
      if ((r_state == WR_D || r_state == RD_D) && !w_dFire) begin
        if (r_toCnt == TO_LAST) begin
          r_toCnt    <= '0;
          r_err      <= 1'b1;
          r_cnt      <= '0;
          r_dReady   <= 1'b0;
          r_rspValid <= 1'b1;
          r_state    <= RSP;
        end else begin
          r_toCnt <= r_toCnt + 1'b1;
        end
      end else begin
        r_toCnt <= '0;
      end
`endif
    end
  end

  assign bus.req_ready       = r_reqReady;
  assign bus.rsp_valid       = r_rspValid;
  assign bus.rsp_rdata       = r_rdata;
  assign bus.rsp_err         = r_err;
  assign bus.tlmst_a_opcode  = r_aOpcode;
  assign bus.tlmst_a_param   = 3'd0;
  assign bus.tlmst_a_size    = r_aSize;
  assign bus.tlmst_a_source  = r_aSource;
  assign bus.tlmst_a_address = r_aAddr;
  assign bus.tlmst_a_mask    = r_aMask;
  assign bus.tlmst_a_data    = r_aData;
  assign bus.tlmst_a_corrupt = 1'b0;
  assign bus.tlmst_a_valid   = r_aValid;
  assign bus.tlmst_d_ready   = r_dReady;
endmodule

// File: tb/tb_tl_line_master.sv
// Bench for tl_line_master: table vectors, random line traffic against a line-memory model,
// plus mid-burst reset and (with TL_MASTER_TIMEOUT_EN) watchdog sequences.
module tb_tl_line_master;
  localparam int         LG    = 2;
  localparam int         BEATS = 4;
  localparam int         LW    = 512;
  localparam logic [2:0] SRC   = 3'd3;
`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_line_master_if #(.LG_BEATS(LG)) bus();

  tl_line_master #(.LG_BEATS(LG), .SRC_ID(SRC), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nChecks = 0;
  int nErrors = 0;
  logic [LW-1:0] memModel [logic [31:0]];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [LW-1:0] wdata;
    int          stall;
    int          errBeat;
    int          errKind;
    int          rspDelay;
    logic [31:0] expAddr;
    bit          expErr;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] lineOf(logic [31:0] a);
    return (a / 64) * 64;
  endfunction

  function automatic logic [LW-1:0] readModel(logic [31:0] la);
    if (memModel.exists(la)) return memModel[la];
    return {16{la ^ 32'hA5A5_0000}};
  endfunction

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full line transaction acting as request source, TL slave and response sink.
  task automatic applyStimulus(input vec_t v);
    logic [LW-1:0] expLine;
    logic [LW-1:0] slaveLine;
    int nA, nD, acc, cyc;
    bit ar;
    nA = v.wr ? BEATS : 1;
    nD = v.wr ? 1 : BEATS;
    slaveLine = readModel(v.expAddr);
    expLine = v.wr ? '0 : slaveLine;

    @(negedge clk);
    checkOutput("req_ready_idle", LW'(bus.req_ready), LW'(1));
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checkOutput("req_ready_busy", LW'(bus.req_ready), LW'(0));

    acc = 0;
    cyc = 0;
    while (acc < nA && cyc < 200) begin
      cyc++;
      case (v.stall)
        0:       ar = 1'b1;
        1:       ar = (cyc % 2 == 1);
        default: ar = ($urandom_range(1, 0) == 1);
      endcase
      bus.tlmst_a_ready = ar;
      if (bus.tlmst_a_valid) begin
        checkOutput("a_opcode", LW'(bus.tlmst_a_opcode), LW'(v.wr ? 3'd0 : 3'd4));
        checkOutput("a_address", LW'(bus.tlmst_a_address), LW'(v.expAddr));
        checkOutput("a_size", LW'(bus.tlmst_a_size), LW'(8'd6));
        checkOutput("a_mask", LW'(bus.tlmst_a_mask), LW'(16'hFFFF));
        checkOutput("a_source", LW'(bus.tlmst_a_source), LW'(SRC));
        checkOutput("a_data", LW'(bus.tlmst_a_data), v.wr ? LW'(v.wdata[128*acc +: 128]) : '0);
        if (ar) acc++;
      end
      @(negedge clk);
    end
    bus.tlmst_a_ready = 1'b0;
    checkOutput("a_beats_accepted", LW'(acc), LW'(nA));
    checkOutput("a_valid_after_burst", LW'(bus.tlmst_a_valid), LW'(0));

    for (int b = 0; b < nD; b++) begin
      if (v.stall == 2) repeat ($urandom_range(2, 0)) @(negedge clk);
      checkOutput("d_ready", LW'(bus.tlmst_d_ready), LW'(1));
      bus.tlmst_d_valid   = 1'b1;
      bus.tlmst_d_opcode  = v.wr ? 3'd0 : 3'd1;
      bus.tlmst_d_data    = v.wr ? 128'd0 : slaveLine[128*b +: 128];
      bus.tlmst_d_denied  = (b == v.errBeat && v.errKind == 1);
      bus.tlmst_d_corrupt = (b == v.errBeat && v.errKind == 2);
      if (b == v.errBeat && v.errKind == 3) bus.tlmst_d_opcode = v.wr ? 3'd1 : 3'd0;
      @(negedge clk);
      bus.tlmst_d_valid   = 1'b0;
      bus.tlmst_d_denied  = 1'b0;
      bus.tlmst_d_corrupt = 1'b0;
    end

    checkOutput("rsp_valid", LW'(bus.rsp_valid), LW'(1));
    checkOutput("rsp_err", LW'(bus.rsp_err), LW'(v.expErr));
    checkOutput("rsp_rdata", bus.rsp_rdata, expLine);
    checkOutput("d_ready_in_rsp", LW'(bus.tlmst_d_ready), LW'(0));
    repeat (v.rspDelay) begin
      @(negedge clk);
      checkOutput("rsp_valid_held", LW'(bus.rsp_valid), LW'(1));
      checkOutput("rsp_rdata_held", bus.rsp_rdata, expLine);
      checkOutput("req_ready_in_rsp", LW'(bus.req_ready), LW'(0));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", LW'(bus.rsp_valid), LW'(0));
    checkOutput("req_ready_back", LW'(bus.req_ready), LW'(1));

    if (v.wr && !v.expErr) memModel[v.expAddr] = v.wdata;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int n;
    logic [LW-1:0] line1, line2, line3;
    line1 = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    line2 = {{4{32'hDEAD_0003}}, {4{32'hDEAD_0002}}, {4{32'hDEAD_0001}}, {4{32'hDEAD_0000}}};
    line3 = {{4{32'hC0DE_0003}}, {4{32'hC0DE_0002}}, {4{32'hC0DE_0001}}, {4{32'hC0DE_0000}}};

    vecs[0] = '{1'b1, 32'h8000_0040, line1, 0, -1, 0, 0, 32'h8000_0040, 1'b0};
    vecs[1] = '{1'b0, 32'h8000_0047, '0,    0, -1, 0, 0, 32'h8000_0040, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_0080, line2, 1, -1, 0, 0, 32'h8000_0080, 1'b0};
    vecs[3] = '{1'b0, 32'h8000_0080, '0,    0,  1, 1, 5, 32'h8000_0080, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_00C5, line3, 0,  0, 3, 1, 32'h8000_00C0, 1'b1};
    vecs[5] = '{1'b0, 32'h8000_00C0, '0,    1,  3, 2, 2, 32'h8000_00C0, 1'b1};

    bus.req_valid = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = 32'd0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.tlmst_a_ready = 1'b0;
    bus.tlmst_d_opcode = 3'd0;
    bus.tlmst_d_denied = 1'b0;
    bus.tlmst_d_data = 128'd0;
    bus.tlmst_d_corrupt = 1'b0;
    bus.tlmst_d_valid = 1'b0;

    #12;
    checkOutput("reset_req_ready", LW'(bus.req_ready), LW'(1));
    checkOutput("reset_a_valid", LW'(bus.tlmst_a_valid), LW'(0));
    checkOutput("reset_d_ready", LW'(bus.tlmst_d_ready), LW'(0));
    checkOutput("reset_rsp_valid", LW'(bus.rsp_valid), LW'(0));
    checkOutput("reset_rsp_rdata", bus.rsp_rdata, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Abandon a write burst mid-flight with an asynchronous reset.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'h8000_0200;
    bus.req_wdata = line2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.tlmst_a_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.tlmst_a_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_a_valid", LW'(bus.tlmst_a_valid), LW'(0));
    checkOutput("midreset_a_data", LW'(bus.tlmst_a_data), '0);
    checkOutput("midreset_req_ready", LW'(bus.req_ready), LW'(1));
    checkOutput("midreset_d_ready", LW'(bus.tlmst_d_ready), LW'(0));
    checkOutput("midreset_rsp_valid", LW'(bus.rsp_valid), LW'(0));
    @(negedge clk);
    rst = 1'b0;
    v = '{1'b0, 32'h8000_0040, '0, 0, -1, 0, 0, 32'h8000_0040, 1'b0};
    applyStimulus(v);

`ifdef TL_MASTER_TIMEOUT_EN
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 32'h8000_0300;
    bus.req_wdata = line3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.tlmst_a_ready = 1'b1;
    n = 0;
    while (!bus.tlmst_d_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.tlmst_a_ready = 1'b0;
    checkOutput("timeout_wr_d_entry", LW'(bus.tlmst_d_ready), LW'(1));
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timeout_cycles", LW'(n), LW'(16));
    checkOutput("timeout_err", LW'(bus.rsp_err), LW'(1));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checkOutput("timeout_req_ready", LW'(bus.req_ready), LW'(1));
`else
    n = 0;
`endif

    for (int t = 0; t < 24; t++) begin
      v.wr = ($urandom_range(1, 0) == 1);
      v.addr = 32'h8000_0000 | ($urandom_range(7, 0) << 6) | $urandom_range(63, 0);
      for (int b = 0; b < 16; b++) v.wdata[32*b +: 32] = $urandom();
      v.stall = 2;
      v.errBeat = ($urandom_range(3, 0) == 0) ? int'($urandom_range(v.wr ? 0 : 3, 0)) : -1;
      v.errKind = int'($urandom_range(3, 1));
      v.rspDelay = int'($urandom_range(3, 0));
      v.expAddr = lineOf(v.addr);
      v.expErr = (v.errBeat >= 0);
      applyStimulus(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
